// File: rtl/spi_tx_framer.sv
// spi_tx_framer: packs a command (opcode, length) and its payload bytes into
// a byte frame SYNC_BYTE, opcode, len, payload[len], checksum and presents it
// on an AXI4-Stream master port, one byte per cycle when unstalled.
//
// Ports:
//   axi_aclk, axi_areset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_opcode, cmd_len             command fields, sampled at accept
//   pay_valid/pay_ready, pay_data   payload byte handshake
//   axis_tvalid/tready/tdata/tlast  frame byte stream (tlast on checksum)
//   busy                            frame in progress or output byte pending
module spi_tx_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       axi_aclk,
    input  logic       axi_areset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_opcode,
    input  logic [7:0] cmd_len,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [7:0] pay_data,
    output logic       axis_tvalid,
    input  logic       axis_tready,
    output logic [7:0] axis_tdata,
    output logic       axis_tlast,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        OP,
        LEN,
        PAY,
        CSUM
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   opcode_q;
    logic [BYTE_W-1:0]   len_q;
    logic [BYTE_W-1:0]   csum_q;
    logic [BYTE_W-1:0]   remain_q;
    logic                slot_free;

    // The single output register may take a new byte when empty or draining.
    assign slot_free = !axis_tvalid || axis_tready;

    // Handshake readies are held low while reset is asserted.
    assign cmd_ready = !axi_areset && (state == IDLE) && slot_free;
    assign pay_ready = !axi_areset && (state == PAY) && slot_free;
    assign busy      = (state != IDLE) || axis_tvalid;

    // Frame sequencer and output register.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state       <= IDLE;
            axis_tvalid <= 1'b0;
            axis_tlast  <= 1'b0;
            axis_tdata  <= '0;
            opcode_q    <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            remain_q    <= '0;
        end else begin
            // A consumed or empty slot defaults to empty unless refilled below;
            // a stalled slot keeps data and tlast untouched.
            if (slot_free) begin
                axis_tvalid <= 1'b0;
                axis_tlast  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && slot_free) begin
                        axis_tdata  <= SYNC_BYTE;
                        axis_tvalid <= 1'b1;
                        opcode_q    <= cmd_opcode;
                        len_q       <= cmd_len;
                        csum_q      <= '0;
                        state       <= OP;
                    end
                end
                OP: begin
                    if (slot_free) begin
                        axis_tdata  <= opcode_q;
                        axis_tvalid <= 1'b1;
                        csum_q      <= csum_q + opcode_q;
                        state       <= LEN;
                    end
                end
                LEN: begin
                    if (slot_free) begin
                        axis_tdata  <= len_q;
                        axis_tvalid <= 1'b1;
                        csum_q      <= csum_q + len_q;
                        remain_q    <= len_q;
                        state       <= (len_q != '0) ? PAY : CSUM;
                    end
                end
                PAY: begin
                    // Without pay_valid the slot stays empty (bubble).
                    if (slot_free && pay_valid) begin
                        axis_tdata  <= pay_data;
                        axis_tvalid <= 1'b1;
                        csum_q      <= csum_q + pay_data;
                        remain_q    <= remain_q - BYTE_W'(1);
                        if (remain_q == BYTE_W'(1)) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (slot_free) begin
                        axis_tdata  <= csum_q;
                        axis_tvalid <= 1'b1;
                        axis_tlast  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_framer.sv
// tb_spi_tx_framer: table of frames driven through spi_tx_framer with a
// scoreboard of expected stream bytes, plus hand-written back-to-back and
// mid-frame reset sequences.
module tb_spi_tx_framer;

    logic       axi_aclk = 1'b0;
    logic       axi_areset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_opcode = 8'h00;
    logic [7:0] cmd_len = 8'h00;
    logic       pay_valid = 1'b0;
    logic       pay_ready;
    logic [7:0] pay_data = 8'h00;
    logic       axis_tvalid;
    logic       axis_tready = 1'b1;
    logic [7:0] axis_tdata;
    logic       axis_tlast;
    logic       busy;

    spi_tx_framer #(.SYNC_BYTE(8'hA5)) dut (
        .axi_aclk    (axi_aclk),
        .axi_areset  (axi_areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_len     (cmd_len),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tdata  (axis_tdata),
        .axis_tlast  (axis_tlast),
        .busy        (busy)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       first;
    } exp_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  len;
        logic [31:0] pay;   // byte i at pay[8*i +: 8]
        logic [7:0]  csum;  // hand-computed expected checksum
        logic        bp;    // random tready and payload gaps
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sync_cyc = 0;
    int   tlast_cyc = 0;
    int   sync_gap = 0;
    int   frame_span = 0;
    int   pr_cnt = 0;
    int   tl_cnt = 0;
    bit   rnd_mode = 1'b0;
    bit   stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge axi_aclk) cyc++;

    // Downstream ready: constant high or pseudo-random.
    initial begin
        forever begin
            @(posedge axi_aclk);
            #1;
            axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor: scoreboard compare on handshake, stability while stalled.
    always @(negedge axi_aclk) begin
        if (!axi_areset) begin
            if (pay_ready) pr_cnt++;
            if (stall_prev) begin
                checks++;
                if (!(axis_tvalid && axis_tdata == prev_data && axis_tlast == prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                             axis_tvalid, axis_tdata, axis_tlast, prev_data, prev_last);
                end
            end
            if (axis_tvalid && axis_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h want none", axis_tdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (axis_tdata !== e.data || axis_tlast !== e.last) begin
                        errors++;
                        $display("FAIL stream_byte: got d=%0h l=%0b want d=%0h l=%0b",
                                 axis_tdata, axis_tlast, e.data, e.last);
                    end
                    if (e.first) begin
                        sync_gap = cyc - tlast_cyc;
                        sync_cyc = cyc;
                    end
                    if (e.last) begin
                        tlast_cyc  = cyc;
                        frame_span = cyc - sync_cyc;
                    end
                end
                if (axis_tlast) tl_cnt++;
            end
            stall_prev = axis_tvalid && !axis_tready;
            prev_data  = axis_tdata;
            prev_last  = axis_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic void push_frame(input vec_t v);
        sb.push_back('{data: 8'hA5, last: 1'b0, first: 1'b1});
        sb.push_back('{data: v.op, last: 1'b0, first: 1'b0});
        sb.push_back('{data: v.len, last: 1'b0, first: 1'b0});
        for (int i = 0; i < int'(v.len); i++)
            sb.push_back('{data: v.pay[8*i +: 8], last: 1'b0, first: 1'b0});
        sb.push_back('{data: v.csum, last: 1'b1, first: 1'b0});
    endfunction

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] len);
        int  n = 0;
        bit  done = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_len    = len;
        while (!done) begin
            @(negedge axi_aclk);
            if (cmd_ready) done = 1'b1;
            else if (++n > 2000) begin
                chk("cmd_timeout", 32'd1, 32'd0);
                done = 1'b1;
            end
            @(posedge axi_aclk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_pay(input vec_t v);
        for (int i = 0; i < int'(v.len); i++) begin
            int  n = 0;
            bit  done = 1'b0;
            if (v.bp) begin
                pay_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge axi_aclk);
                    #1;
                end
            end
            pay_valid = 1'b1;
            pay_data  = v.pay[8*i +: 8];
            while (!done) begin
                @(negedge axi_aclk);
                if (pay_ready) done = 1'b1;
                else if (++n > 2000) begin
                    chk("pay_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
                @(posedge axi_aclk);
                #1;
            end
        end
        pay_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || axis_tvalid) && n < 2000) begin
            @(negedge axi_aclk);
            n++;
        end
        @(negedge axi_aclk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        rnd_mode = v.bp;
        pr_cnt = 0;
        push_frame(v);
        fork
            send_cmd(v.op, v.len);
            send_pay(v);
        join
        drain();
        rnd_mode = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{op: 8'h12, len: 8'd2, pay: 32'h0000_0201, csum: 8'h17, bp: 1'b0};
        vecs[1] = '{op: 8'h30, len: 8'd0, pay: 32'h0,         csum: 8'h30, bp: 1'b0};
        vecs[2] = '{op: 8'hFF, len: 8'd1, pay: 32'h0000_0080, csum: 8'h80, bp: 1'b0};
        vecs[3] = '{op: 8'h12, len: 8'd2, pay: 32'h0000_0201, csum: 8'h17, bp: 1'b1};
        vecs[4] = '{op: 8'h5A, len: 8'd4, pay: 32'hF030_2010, csum: 8'hAE, bp: 1'b1};

        // Reset state.
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_pay_ready", 32'(pay_ready), 32'd0);
        chk("rst_tvalid", 32'(axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(axis_tlast), 32'd0);
        chk("rst_tdata", 32'(axis_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge axi_aclk);
        #1;
        axi_areset = 1'b0;
        @(negedge axi_aclk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge axi_aclk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
            if (i == 0) chk("basic_span", 32'(frame_span), 32'd5);
            if (vecs[i].len == 8'd0) chk("zero_len_pay_ready", 32'(pr_cnt), 32'd0);
        end

        // Back-to-back: basic frame then zero-length frame, no gap.
        push_frame(vecs[0]);
        push_frame(vecs[1]);
        fork
            begin
                send_cmd(vecs[0].op, vecs[0].len);
                send_cmd(vecs[1].op, vecs[1].len);
            end
            send_pay(vecs[0]);
        join
        drain();
        chk("b2b_sync_gap", 32'(sync_gap), 32'd1);

        // Reset mid-frame while in PAY.
        begin
            int n = 0;
            int tl_before;
            tl_before = tl_cnt;
            sb.push_back('{data: 8'hA5, last: 1'b0, first: 1'b1});
            sb.push_back('{data: 8'h40, last: 1'b0, first: 1'b0});
            sb.push_back('{data: 8'h03, last: 1'b0, first: 1'b0});
            pay_valid = 1'b1;
            pay_data  = 8'h11;
            send_cmd(8'h40, 8'd3);
            while (!pay_ready && n < 100) begin
                @(negedge axi_aclk);
                n++;
            end
            chk("rst_mid_reach_pay", 32'(pay_ready), 32'd1);
            @(posedge axi_aclk);
            #1;
            pay_valid  = 1'b0;
            axi_areset = 1'b1;
            @(posedge axi_aclk);
            #1;
            chk("rst_mid_tvalid", 32'(axis_tvalid), 32'd0);
            chk("rst_mid_tlast", 32'(axis_tlast), 32'd0);
            chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("rst_mid_pay_ready", 32'(pay_ready), 32'd0);
            chk("rst_mid_no_tlast", 32'(tl_cnt), 32'(tl_before));
            sb.delete();
            axi_areset = 1'b0;
            @(negedge axi_aclk);
            chk("rst_mid_cmd_ready_up", 32'(cmd_ready), 32'd1);
            @(posedge axi_aclk);
            #1;
            run_frame(vecs[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/spi_tx_framer.md
SPI_TX_FRAMER -- requirements
Module: spi_tx_framer

Interface
REQ-001 SHALL have parameter: SYNC_BYTE, 8'hA5, first byte of every frame.
REQ-002 SHALL have port: axi_aclk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: axi_areset  input  1  synchronous active-high reset, sampled on axi_aclk.
REQ-004 SHALL have port: cmd_valid  input  1  command request.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port: cmd_opcode  input  8  frame opcode, sampled at command accept.
REQ-007 SHALL have port: cmd_len  input  8  payload byte count, 0..255, sampled at command accept.
REQ-008 SHALL have port: pay_valid  input  1  payload byte available.
REQ-009 SHALL have port: pay_ready  output  1  payload byte consumed when pay_valid && pay_ready.
REQ-010 SHALL have port: pay_data  input  8  payload byte.
REQ-011 SHALL have port: axis_tvalid  output  1  AXI4-Stream master valid, feeding spi_send axis_rvalid.
REQ-012 SHALL have port: axis_tready  input  1  downstream ready (spi_send axis_rready).
REQ-013 SHALL have port: axis_tdata  output  8  frame byte.
REQ-014 SHALL have port: axis_tlast  output  1  high on the checksum byte only.
REQ-015 SHALL have port: busy  output  1  high whenever state is not IDLE or axis_tvalid is high.

Function
REQ-016 SHALL emit each frame as: SYNC_BYTE, opcode, len, len payload bytes, checksum.
REQ-017 SHALL compute checksum as (opcode + len + sum of payload bytes) mod 256, accumulated in an 8-bit register that wraps.
REQ-018 SHALL hold axis_tvalid/axis_tdata/axis_tlast in a single output register; "slot free" = !axis_tvalid || axis_tready.
REQ-019 SHALL keep axis_tdata and axis_tlast stable while axis_tvalid && !axis_tready.
REQ-020 SHALL use states IDLE, OP, LEN, PAY, CSUM.
REQ-021 SHALL drive cmd_ready = (state == IDLE) && slot free.
REQ-022 SHALL, on command accept, load SYNC_BYTE into the output register, latch opcode and len, clear checksum, and go to OP; axis_tvalid is high on the next cycle (latency 1).
REQ-023 SHALL, in OP with slot free, load opcode and go to LEN.
REQ-024 SHALL, in LEN with slot free, load len and go to PAY if len != 0, else to CSUM.
REQ-025 SHALL drive pay_ready = (state == PAY) && slot free.
REQ-026 SHALL, on payload handshake, load pay_data and decrement a remaining counter; on the last byte go to CSUM.
REQ-027 SHALL, in PAY with slot free and pay_valid low, clear axis_tvalid (bubble) and stay in PAY.
REQ-028 SHALL, in CSUM with slot free, load the checksum with axis_tlast=1 and go to IDLE.
REQ-029 SHALL accept the next command in the same cycle the checksum byte handshakes; with axis_tready constantly high, there are no idle cycles between frames.
REQ-030 SHALL sustain 1 byte/cycle; a frame of N payload bytes occupies N+4 consecutive tvalid cycles when pay_valid and axis_tready are constantly high.
REQ-031 SHALL never assert pay_ready outside PAY and never consume more than len payload bytes per frame.
REQ-032 SHALL ignore cmd_valid while not in IDLE; the command is held by the source until accepted.

Reset
REQ-033 SHALL, while axi_areset is high on a clock edge, set state=IDLE, axis_tvalid=0, axis_tlast=0, axis_tdata=0, checksum=0, counter=0; cmd_ready=0 and pay_ready=0 during reset.
REQ-034 SHALL, on reset mid-frame, drop the frame without emitting tlast; axis_tvalid is 0 on the cycle after the reset edge.
REQ-035 SHALL allow cmd_ready to rise on the first cycle after reset deasserts.

Verification
REQ-036 SHALL test basic frame: opcode 0x12, len 2, payload 01 02, tready=1 -> A5 12 02 01 02 17, tlast on 0x17 only, 6 consecutive cycles.
REQ-037 SHALL test zero length: opcode 0x30, len 0 -> A5 30 00 30, pay_ready never high.
REQ-038 SHALL test checksum wrap: opcode 0xFF, len 1, payload 0x80 -> A5 FF 01 80 80.
REQ-039 SHALL test backpressure: tready toggled pseudo-randomly, and pay_valid gapped -> identical byte sequence to REQ-036, data stable while stalled, no loss or duplication.
REQ-040 SHALL test back-to-back: two commands queued with tready=1 -> second SYNC_BYTE on the cycle after the first checksum, no gap.
REQ-041 SHALL test reset mid-frame: assert axi_areset during PAY -> tvalid=0 the next cycle, no tlast; the next command yields a complete correct frame.
